mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch port and its data (load/store) port.
- Each port uses a req/ack handshake. The block stalls the losing port, sequences one memory transaction at a time, and returns read data to the winner.
- Sits between the PC / instruction-fetch logic, the MEM-stage load/store logic and the external memory model.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- WAIT_MAX, 15, grant-cycle limit before the watchdog fires (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- if_req_i  in  1  fetch request; address held stable until if_ack_o
- if_addr_i  in  ADDR_W  fetch address
- if_ack_o  out  1  fetch done; one-cycle pulse
- if_rdata_o  out  DATA_W  fetched instruction; valid only while if_ack_o=1
- if_stall_o  out  1  = if_req_i & ~if_ack_o
- d_req_i  in  1  data request; inputs held stable until d_ack_o
- d_we_i  in  1  1=store, 0=load
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_ack_o  out  1  data done; one-cycle pulse
- d_rdata_o  out  DATA_W  load data; valid only while d_ack_o=1 and the request was a load
- d_stall_o  out  1  = d_req_i & ~d_ack_o
- mem_req_o  out  1  memory request (registered)
- mem_we_o  out  1  memory write enable (registered)
- mem_addr_o  out  ADDR_W  memory address (registered)
- mem_wdata_o  out  DATA_W  memory write data (registered)
- mem_ack_i  in  1  memory done; mem_rdata_i valid in the same cycle
- mem_rdata_i  in  DATA_W  memory read data
- err_o  out  1  watchdog error flag (sticky); tied 0 without the optional feature

Behaviour:
- FSM states: IDLE, GNT_IF, GNT_D.
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; mem_req_o, mem_we_o = 0; mem_addr_o, mem_wdata_o = 0.
  - All acks = 0; err_o = 0.
  - rdata outputs = 0.
- IDLE:
  - d_req_i=1 → GNT_D. Data port wins ties: it holds the older instruction.
  - else if_req_i=1 → GNT_IF.
  - else stay in IDLE.
  - On the grant edge, register mem_req_o=1 and the winner's addr, we and wdata. For a fetch, mem_we_o=0.
- GNT_x:
  - mem_req_o and the mem_* outputs are held constant until mem_ack_i=1.
  - x_ack_o = mem_ack_i & (state==GNT_x). This is combinational; there is no extra cycle.
- rdata routing:
  - if_rdata_o = mem_rdata_i while if_ack_o=1, else 0.
  - d_rdata_o = mem_rdata_i while d_ack_o=1 and mem_we_o=0, else 0.
- On mem_ack_i=1: the next state is IDLE and mem_req_o clears on the same edge. There is no back-to-back grant from GNT_x; IDLE always costs one cycle.
- Latency: request seen in cycle N → mem_req_o=1 at N+1 → ack in the first cycle with mem_ack_i=1, earliest N+1.
- mem_ack_i in IDLE is ignored. This covers a stale ack after a reset mid-transaction.
- A requester dropping req while granted is illegal. The block keeps the transaction and still pulses the ack.
- Both requests held continuously: without the optional feature, data wins every IDLE, so fetch can starve. This is accepted because the data port deasserts when MEM advances.

Optional Feature:
- Macro: MEM_ARB_WATCHDOG_EN.
- Defined:
  - A 4-bit+ counter clears on entering GNT_x and increments each cycle in GNT_x without mem_ack_i.
  - When the count reaches WAIT_MAX, set err_o=1 (sticky until reset), force state=IDLE, clear mem_req_o, and pulse no ack.
  - The requester keeps its req and is re-arbitrated.
- Undefined: no counter; err_o tied 0; GNT_x waits indefinitely.

Test Plan:
- Fetch only: if_req_i=1, if_addr_i=0x10; memory acks 2 cycles after mem_req_o with rdata 0x8C220004 → mem_addr_o=0x10, mem_we_o=0; if_ack_o for exactly 1 cycle; if_rdata_o=0x8C220004; if_stall_o high until then.
- Simultaneous: if_req_i=1 (0x20) and d_req_i=1 load (0x100), same cycle → d_ack_o first with mem_addr_o=0x100; after one IDLE cycle, fetch granted at 0x20.
- Store: d_req_i=1, d_we_i=1, addr 0x40, wdata 0xDEADBEEF, 0-wait memory → mem_we_o=1, mem_wdata_o=0xDEADBEEF; d_ack_o one cycle after request; d_rdata_o=0.
- Reset mid-transaction: rst_i pulsed in GNT_IF before mem_ack_i; mem_ack_i then arrives while in IDLE → mem_req_o=0 immediately; no if_ack_o; state stays IDLE.
- Back-to-back loads: d_req_i held for two loads (0x0, then 0x4), each 1-wait → exactly one IDLE cycle between the mem_req_o assertions; two d_ack_o pulses with correct data.
- Watchdog (MEM_ARB_WATCHDOG_EN, WAIT_MAX=15): mem_ack_i held 0 → after 15 grant cycles, err_o=1 and mem_req_o=0; the request is re-granted next cycle; err_o stays 1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data ports; data wins ties.
// Optional watchdog (define MEM_ARB_WATCHDOG_EN) aborts a grant stuck for WAIT_MAX cycles.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_ack_o,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_stall_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_ack_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_stall_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              err_o
);

   typedef enum logic [1:0] {StIdle, StGntIf, StGntD} state_t;

   state_t            r_state;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              w_if_ack;
   logic              w_d_ack;

   // Acks come straight from the memory ack so the winner sees no extra cycle.
   assign w_if_ack = mem_ack_i & (r_state == StGntIf);
   assign w_d_ack  = mem_ack_i & (r_state == StGntD);

   assign if_ack_o    = w_if_ack;
   assign d_ack_o     = w_d_ack;
   assign if_stall_o  = if_req_i & ~w_if_ack;
   assign d_stall_o   = d_req_i & ~w_d_ack;
   assign if_rdata_o  = w_if_ack ? mem_rdata_i : '0;
   assign d_rdata_o   = (w_d_ack && !r_mem_we) ? mem_rdata_i : '0;
   assign mem_req_o   = r_mem_req;
   assign mem_we_o    = r_mem_we;
   assign mem_addr_o  = r_mem_addr;
   assign mem_wdata_o = r_mem_wdata;

`ifdef MEM_ARB_WATCHDOG_EN
   localparam int unsigned CntW = (WAIT_MAX < 16) ? 4 : $clog2(WAIT_MAX + 1);

   logic [CntW-1:0] r_wait_cnt;
   logic            r_err;
   logic            w_timeout;

   // Fires on the edge that would take the count to WAIT_MAX.
   assign w_timeout = (r_state != StIdle) && !mem_ack_i &&
                      (r_wait_cnt == CntW'(WAIT_MAX - 1));
   assign err_o     = r_err;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wait_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         if (r_state == StIdle || mem_ack_i || w_timeout) begin
            r_wait_cnt <= '0;
         end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
         if (w_timeout) begin
            r_err <= 1'b1;
         end
      end
   end
`else
   logic w_wait_max_unused;

   assign w_wait_max_unused = |WAIT_MAX;
   assign err_o             = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= StIdle;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (d_req_i) begin
                  r_state     <= StGntD;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= d_we_i;
                  r_mem_addr  <= d_addr_i;
                  r_mem_wdata <= d_wdata_i;
               end else if (if_req_i) begin
                  r_state     <= StGntIf;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= if_addr_i;
                  r_mem_wdata <= '0;
               end
            end
            StGntIf, StGntD: begin
               if (mem_ack_i) begin
                  r_state   <= StIdle;
                  r_mem_req <= 1'b0;
`ifdef MEM_ARB_WATCHDOG_EN
               end else if (w_timeout) begin
                  r_state   <= StIdle;
                  r_mem_req <= 1'b0;
`endif
               end
            end
            default: begin
               r_state   <= StIdle;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
